// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// RISC-V load/store funct3 codes.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check of a data access from its funct3 width
// code and the two low address bits.
module mem_align_check
  import riscv_mem_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (funct3)
      F3_LH, F3_LHU: misaligned = addr_lo[0];
      F3_LW:         misaligned = |addr_lo;
      default:       misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared I+D memory port between instruction fetch and data
// access, data first. Optional alignment trap enabled by MEM_ALIGN_CHECK_EN.
module mem_port_arbiter
  import riscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [2:0]  dm_funct3,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        misalign
);

  arb_state_e  state_q, state_d;
  logic        dm_pend_q, dm_pend_d;
  logic        dm_rd_q, dm_rd_d;
  logic        dm_wr_q, dm_wr_d;
  logic        if_pend_q, if_pend_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [2:0]  dm_f3_q, dm_f3_d;
  logic [31:0] if_addr_q, if_addr_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        dm_valid_q, dm_valid_d;
  logic        misalign_q, misalign_d;
  logic        mis_w;

`ifdef MEM_ALIGN_CHECK_EN
  mem_align_check u_align (
    .funct3     (dm_f3_q),
    .addr_lo    (dm_addr_q[1:0]),
    .misaligned (mis_w)
  );
`else
  assign mis_w = 1'b0;
`endif

  assign stall    = (state_q != IDLE);
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign dm_valid = dm_valid_q;
  assign dm_rdata = dm_rdata_q;
  assign misalign = misalign_q;

  always_comb begin
    state_d    = state_q;
    dm_pend_d  = dm_pend_q;
    dm_rd_d    = dm_rd_q;
    dm_wr_d    = dm_wr_q;
    if_pend_d  = if_pend_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dm_f3_d    = dm_f3_q;
    if_addr_d  = if_addr_q;
    if_instr_d = if_instr_q;
    dm_rdata_d = dm_rdata_q;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    misalign_d = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_funct3 = 3'd0;

    case (state_q)
      IDLE: begin
        dm_pend_d = dm_read | dm_write;
        dm_rd_d   = dm_read;
        dm_wr_d   = dm_write;
        if_pend_d = if_req;
        if (dm_read | dm_write) begin
          dm_addr_d  = dm_addr;
          dm_wdata_d = dm_wdata;
          dm_f3_d    = dm_funct3;
        end
        if (if_req) if_addr_d = if_addr;
        if (dm_read | dm_write) state_d = DATA;
        else if (if_req)        state_d = FETCH;
      end
      DATA: begin
        mem_read   = dm_rd_q & ~mis_w;
        mem_write  = dm_wr_q & ~mis_w;
        mem_addr   = dm_addr_q;
        mem_wdata  = dm_wdata_q;
        mem_funct3 = dm_f3_q;
        if (dm_rd_q) dm_rdata_d = mis_w ? 32'd0 : mem_rdata;
        if (if_pend_q) begin
          state_d = FETCH;
        end else begin
          state_d    = IDLE;
          dm_valid_d = 1'b1;
          misalign_d = mis_w;
        end
      end
      FETCH: begin
        mem_read   = 1'b1;
        mem_addr   = if_addr_q;
        mem_funct3 = F3_LW;
        if_instr_d = mem_rdata;
        state_d    = IDLE;
        // Any data access in this transaction finished in DATA; report both now.
        if_valid_d = 1'b1;
        dm_valid_d = dm_pend_q;
        misalign_d = dm_pend_q & mis_w;
      end
      default: state_d = IDLE;
    endcase

    // Reset can land mid-access; never let a strobe reach memory then.
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dm_pend_q  <= 1'b0;
      dm_rd_q    <= 1'b0;
      dm_wr_q    <= 1'b0;
      if_pend_q  <= 1'b0;
      if_instr_q <= 32'd0;
      dm_rdata_q <= 32'd0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_pend_q  <= dm_pend_d;
      dm_rd_q    <= dm_rd_d;
      dm_wr_q    <= dm_wr_d;
      if_pend_q  <= if_pend_d;
      if_instr_q <= if_instr_d;
      dm_rdata_q <= dm_rdata_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    dm_addr_q  <= dm_addr_d;
    dm_wdata_q <= dm_wdata_d;
    dm_f3_q    <= dm_f3_d;
    if_addr_q  <= if_addr_d;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random transactions
// checked against a transaction-level model of the shared memory.
module tb_mem_port_arbiter;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_read, dm_write;
  logic [31:0] dm_addr, dm_wdata;
  logic [2:0]  dm_funct3;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;
  logic        stall, if_valid, dm_valid, misalign;
  logic [31:0] if_instr, dm_rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] env_mem [256];
  bit          env_wr  [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_dm_rdata, exp_if_instr;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_funct3(dm_funct3),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata),
    .stall(stall), .if_valid(if_valid), .if_instr(if_instr),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata), .misalign(misalign)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      2:       return 32'h00A00093;
      4:       return 32'h00000011;
      default: return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  function automatic logic [31:0] env_rd(input logic [7:0] i);
    return env_wr[i] ? env_mem[i] : init_word(int'(i));
  endfunction

  assign mem_rdata = env_rd(mem_addr[9:2]);

  always @(posedge clk) begin
    if (mem_write) begin
      env_mem[mem_addr[9:2]] <= mem_wdata;
      env_wr[mem_addr[9:2]]  <= 1'b1;
    end
  end

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b001 || f3 == 3'b101) return a[0];
    if (f3 == 3'b010)                 return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one acceptance from an IDLE negedge and follow it to its valid cycle.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] da, input logic [31:0] dw,
                     input logic ir, input logic [31:0] ia);
    bit has_d, mis;
    int exp_stall, cyc;
    has_d = rd | wr;
    mis   = ALIGN_EN && has_d && is_mis(f3, da);
    exp_stall = int'(has_d) + int'(ir);
    dm_read = rd; dm_write = wr; dm_funct3 = f3; dm_addr = da; dm_wdata = dw;
    if_req = ir; if_addr = ia;
    if (rd) exp_dm_rdata = mis ? 32'd0 : ref_mem[da[9:2]];
    if (wr && !mis) ref_mem[da[9:2]] = dw;
    if (ir) exp_if_instr = ref_mem[ia[9:2]];
    @(posedge clk);
    @(negedge clk);
    cyc = 0;
    while (stall && cyc < 8) begin
      if (cyc == 0 && has_d) begin
        chk("data_mem_read",  {31'd0, mem_read},  {31'd0, rd & ~mis});
        chk("data_mem_write", {31'd0, mem_write}, {31'd0, wr & ~mis});
        chk("data_mem_addr",  mem_addr, da);
        chk("data_mem_f3",    {29'd0, mem_funct3}, {29'd0, f3});
        chk("data_mem_wdata", mem_wdata, dw);
      end else begin
        chk("fetch_mem_read",  {31'd0, mem_read},  32'd1);
        chk("fetch_mem_write", {31'd0, mem_write}, 32'd0);
        chk("fetch_mem_addr",  mem_addr, ia);
        chk("fetch_mem_f3",    {29'd0, mem_funct3}, 32'd2);
        chk("fetch_mem_wdata", mem_wdata, 32'd0);
      end
      cyc++;
      @(negedge clk);
    end
    chk("stall_cycles", cyc, exp_stall);
    chk("if_valid",  {31'd0, if_valid}, {31'd0, ir});
    chk("dm_valid",  {31'd0, dm_valid}, {31'd0, has_d});
    chk("misalign",  {31'd0, misalign}, {31'd0, mis});
    chk("dm_rdata",  dm_rdata, exp_dm_rdata);
    chk("if_instr",  if_instr, exp_if_instr);
    chk("idle_mem_read", {31'd0, mem_read | mem_write}, 32'd0);
    chk("idle_mem_addr", mem_addr, 32'd0);
    dm_read = 1'b0; dm_write = 1'b0; if_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_stall"},    {31'd0, stall}, 32'd0);
    chk({pfx, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    chk({pfx, "_dm_valid"}, {31'd0, dm_valid}, 32'd0);
    chk({pfx, "_misalign"}, {31'd0, misalign}, 32'd0);
    chk({pfx, "_dm_rdata"}, dm_rdata, 32'd0);
    chk({pfx, "_if_instr"}, if_instr, 32'd0);
    chk({pfx, "_mem_rw"},   {30'd0, mem_read, mem_write}, 32'd0);
    chk({pfx, "_mem_addr"}, mem_addr, 32'd0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    logic [2:0] rd_f3 [5];
    rd_f3[0] = 3'b000; rd_f3[1] = 3'b001; rd_f3[2] = 3'b010;
    rd_f3[3] = 3'b100; rd_f3[4] = 3'b101;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    exp_dm_rdata = 32'd0;
    exp_if_instr = 32'd0;
    rst = 1'b1; if_req = 1'b0; if_addr = 32'd0;
    dm_read = 1'b0; dm_write = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_funct3 = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios
    txn(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    txn(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 32'h8);
    chk("fetch_word", if_instr, 32'h00A00093);
    txn(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 32'h4);
    chk("load_word", dm_rdata, 32'h00000011);
    txn(1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 1'b0, 32'h0);
    chk("store_keeps_rdata", dm_rdata, 32'h00000011);
    txn(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0);
    chk("load_after_store", dm_rdata, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, 1'b0, 32'h0);
    txn(1'b0, 1'b1, 3'b001, 32'h31, 32'h12345678, 1'b1, 32'h30);

    // Reset during the DATA cycle of a store
    dm_write = 1'b1; dm_funct3 = 3'b010; dm_addr = 32'h24; dm_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_mem_write", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    dm_write = 1'b0;
    #1;
    chk("rst_gates_write", {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("mid_rst");
    exp_dm_rdata = 32'd0;
    exp_if_instr = 32'd0;
    rst = 1'b0;
    chk("rst_mem_untouched", env_rd(8'd9), ref_mem[9]);
    @(negedge clk);

    // Random back-to-back traffic
    for (int n = 0; n < 200; n++) begin
      logic        r, w, f;
      logic [2:0]  f3;
      logic [31:0] a, d, ia;
      int kind;
      kind = int'($urandom_range(0, 2));
      r  = (kind == 1);
      w  = (kind == 2);
      f  = $urandom_range(0, 1) == 1;
      f3 = w ? 3'b010 : rd_f3[$urandom_range(0, 4)];
      a  = 32'($urandom_range(0, 1023));
      d  = $urandom;
      ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      txn(r, w, f3, a, d, f, ia);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
